// File: rtl/main_fsm_pkg.sv
// main_fsm_pkg: shared encodings for the multicycle control unit, the
// datapath muxes and the ALU decoder. Optional feature macro used by the
// consumers of this package: MAIN_FSM_UTYPE_EN.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_EXECU,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_ILLEGAL,
    S_FAULT
  } state_t;

  // Opcode field values
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU decoder request
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Writeback / PC source select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Bundle of all state-decoded control outputs
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       retire;
    logic       trap;
    logic       fault;
  } ctl_t;

  // Immediate format follows the opcode regardless of state
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_ITYPE: imm_sel = IMM_I;
      OP_STORE:          imm_sel = IMM_S;
      OP_BRANCH:         imm_sel = IMM_B;
      OP_JAL:            imm_sel = IMM_J;
      OP_LUI, OP_AUIPC:  imm_sel = IMM_U;
      default:           imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/main_fsm_if.sv
// main_fsm_if: instruction-register opcode, memory handshake and datapath
// control bundle between the control unit (master) and the datapath (slave).
interface main_fsm_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_update;
  logic       branch;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic       retire;
  logic       trap;
  logic       fault;

  modport master (
    input  op, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_update, branch,
           reg_write, alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           retire, trap, fault
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_update, branch,
           reg_write, alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           retire, trap, fault
  );
endinterface

// File: rtl/main_fsm_mem_stall_timer.sv
// mem_stall_timer: counts stalled cycles of the current memory access,
// saturating at MEM_TIMEOUT; timeout is raised while the count sits at the
// limit. MEM_TIMEOUT=0 disables the timeout.
module mem_stall_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic stall,
  output logic timeout
);
  localparam int unsigned TO_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);

  logic [TO_W-1:0] count;

  // Stall counter: clear has priority, then saturating increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (stall && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = (MEM_TIMEOUT != 0) && (count == LIMIT);
endmodule

// File: rtl/main_fsm.sv
// main_fsm: multicycle RV32I control unit sequencing FETCH/DECODE/EXECUTE/
// MEM/WB with a bounded memory stall, illegal-opcode trap and retire pulse.
// Optional macro MAIN_FSM_UTYPE_EN adds lui/auipc through the EXECU state;
// without it both opcodes trap.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  main_fsm_if.master    bus
);

  state_t state;
  state_t state_next;
  ctl_t   ctl;
  logic   timeout;
  logic   in_mem;
  logic   stall;
  logic   clear;

  assign in_mem = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign stall  = in_mem && !bus.mem_ready;
  // Any state change clears the timer, so every entry into a memory state
  // (including FETCH straight after MEMWRITE) starts from zero.
  assign clear  = (state_next != state);

  mem_stall_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .stall  (stall),
    .timeout(timeout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: memory states wait on mem_ready (ready beats timeout)
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (bus.mem_ready)  state_next = S_DECODE;
        else if (timeout)   state_next = S_FAULT;
      end
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
`ifdef MAIN_FSM_UTYPE_EN
          OP_LUI, OP_AUIPC:  state_next = S_EXECU;
`else
          OP_LUI, OP_AUIPC:  state_next = S_ILLEGAL;
`endif
          default:           state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_next = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (bus.mem_ready)  state_next = S_MEMWB;
        else if (timeout)   state_next = S_FAULT;
      end
      S_MEMWRITE: begin
        if (bus.mem_ready)  state_next = S_FETCH;
        else if (timeout)   state_next = S_FAULT;
      end
      S_MEMWB:    state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
`ifdef MAIN_FSM_UTYPE_EN
      S_EXECU:    state_next = S_ALUWB;
`endif
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_ILLEGAL:  state_next = S_FETCH;
      S_FAULT:    state_next = S_FAULT;
      default:    state_next = S_FETCH;
    endcase
  end

  // Output decode: Moore from state, with FETCH/MEMWRITE handshake qualifiers
  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_req    = 1'b1;
        ctl.alu_src_a  = SRCA_PC;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.alu_op     = ALUOP_ADD;
        ctl.result_src = RES_ALU;
        ctl.ir_write   = bus.mem_ready;
        ctl.pc_update  = bus.mem_ready;
      end
      S_DECODE: begin
        ctl.alu_src_a = SRCA_OLDPC;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctl.mem_req = 1'b1;
        ctl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctl.result_src = RES_RDATA;
        ctl.reg_write  = 1'b1;
        ctl.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.mem_req   = 1'b1;
        ctl.mem_write = 1'b1;
        ctl.adr_src   = 1'b1;
        ctl.retire    = bus.mem_ready;
      end
      S_EXECR: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_RS2;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_FUNCT;
      end
`ifdef MAIN_FSM_UTYPE_EN
      S_EXECU: begin
        ctl.alu_src_a = (bus.op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
`endif
      S_ALUWB: begin
        ctl.result_src = RES_ALUOUT;
        ctl.reg_write  = 1'b1;
        ctl.retire     = 1'b1;
      end
      S_BEQ: begin
        ctl.alu_src_a  = SRCA_RS1;
        ctl.alu_src_b  = SRCB_RS2;
        ctl.alu_op     = ALUOP_SUB;
        ctl.result_src = RES_ALUOUT;
        ctl.branch     = 1'b1;
        ctl.retire     = 1'b1;
      end
      S_JAL: begin
        ctl.alu_src_a  = SRCA_OLDPC;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.alu_op     = ALUOP_ADD;
        ctl.result_src = RES_ALUOUT;
        ctl.pc_update  = 1'b1;
      end
      S_ILLEGAL: begin
        ctl.trap = 1'b1;
      end
      S_FAULT: begin
        ctl.fault = 1'b1;
      end
      default: begin
        ctl = '0;
      end
    endcase
  end

  assign bus.mem_req    = ctl.mem_req;
  assign bus.mem_write  = ctl.mem_write;
  assign bus.adr_src    = ctl.adr_src;
  assign bus.ir_write   = ctl.ir_write;
  assign bus.pc_update  = ctl.pc_update;
  assign bus.branch     = ctl.branch;
  assign bus.reg_write  = ctl.reg_write;
  assign bus.alu_src_a  = ctl.alu_src_a;
  assign bus.alu_src_b  = ctl.alu_src_b;
  assign bus.alu_op     = ctl.alu_op;
  assign bus.result_src = ctl.result_src;
  assign bus.imm_src    = imm_sel(bus.op);
  assign bus.retire     = ctl.retire;
  assign bus.trap       = ctl.trap;
  assign bus.fault      = ctl.fault;

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: directed bench for main_fsm. A route-based model (per-opcode
// step string, stall budget as an integer) predicts every output each cycle;
// literal checks pin key cycles of the test plan.
module tb_main_fsm;
  localparam int unsigned TB_TO = 15;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   n_retire, n_memwrite, n_branch, n_trap;

  main_fsm_if bus ();

  main_fsm #(.MEM_TIMEOUT(TB_TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] outs();
    return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_update,
            bus.branch, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.result_src, bus.imm_src, bus.retire, bus.trap, bus.fault};
  endfunction

  // ---------------- model ----------------
  // Steps: F fetch, D decode, A address, R read, W load-writeback, S store,
  // X reg-reg, I reg-imm, U upper-imm, L alu-writeback, B branch, J jump,
  // T trap, Z fault.
  byte   cur = "F";
  byte   prev;
  string route = "";
  int    rpos = 0;
  int    waited = 0;

  function automatic string plan(input logic [6:0] o);
    case (o)
      7'b0000011: return "ARW";
      7'b0100011: return "AS";
      7'b0110011: return "XL";
      7'b0010011: return "IL";
      7'b1100011: return "B";
      7'b1101111: return "JL";
`ifdef MAIN_FSM_UTYPE_EN
      7'b0110111, 7'b0010111: return "UL";
`else
      7'b0110111, 7'b0010111: return "T";
`endif
      default: return "T";
    endcase
  endfunction

  task automatic advance();
    if (rpos < route.len()) begin
      cur = route[rpos];
      rpos++;
    end else begin
      cur = "F";
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cur = "F"; route = ""; rpos = 0; waited = 0;
    end else begin
      prev = cur;
      case (cur)
        "F", "R", "S": begin
          if (bus.mem_ready) begin
            if (cur == "F") cur = "D";
            else advance();
          end else if (waited == TB_TO) begin
            cur = "Z";
          end else begin
            waited++;
          end
        end
        "D": begin
          route = plan(bus.op); rpos = 0; advance();
        end
        "Z": ;
        default: advance();
      endcase
      if (cur != prev) waited = 0;
    end
  end

  function automatic logic [20:0] expect_out(input byte s, input logic rdy, input logic [6:0] o);
    logic mreq, mwr, adr, irw, pcu, br, rw, ret, trp, flt;
    logic [1:0] a, b, aop, res;
    logic [2:0] imm;
    {mreq, mwr, adr, irw, pcu, br, rw, ret, trp, flt} = '0;
    a = '0; b = '0; aop = '0; res = '0;
    case (o)
      7'b0100011: imm = 3'd1;
      7'b1100011: imm = 3'd2;
      7'b1101111: imm = 3'd3;
      7'b0110111, 7'b0010111: imm = 3'd4;
      default: imm = 3'd0;
    endcase
    case (s)
      "F": begin mreq = 1; irw = rdy; pcu = rdy; b = 2'd2; res = 2'd2; end
      "D": begin a = 2'd1; b = 2'd1; end
      "A": begin a = 2'd2; b = 2'd1; end
      "R": begin mreq = 1; adr = 1; end
      "W": begin res = 2'd1; rw = 1; ret = 1; end
      "S": begin mreq = 1; mwr = 1; adr = 1; ret = rdy; end
      "X": begin a = 2'd2; aop = 2'd2; end
      "I": begin a = 2'd2; b = 2'd1; aop = 2'd2; end
      "U": begin a = (o == 7'b0110111) ? 2'd3 : 2'd1; b = 2'd1; end
      "L": begin rw = 1; ret = 1; end
      "B": begin a = 2'd2; aop = 2'd1; br = 1; ret = 1; end
      "J": begin a = 2'd1; b = 2'd2; pcu = 1; end
      "T": trp = 1;
      "Z": flt = 1;
      default: ;
    endcase
    return {mreq, mwr, adr, irw, pcu, br, rw, a, b, aop, res, imm, ret, trp, flt};
  endfunction

  // Per-cycle comparison against the model, plus event tallies
  always @(negedge clk) begin
    check("outputs", 32'(outs()), 32'(expect_out(cur, bus.mem_ready, bus.op)));
    if (bus.retire)    n_retire++;
    if (bus.mem_write) n_memwrite++;
    if (bus.branch)    n_branch++;
    if (bus.trap)      n_trap++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_retire = 0; n_memwrite = 0; n_branch = 0; n_trap = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    bus.op = 7'b0000011;
    bus.mem_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst_mem_req", 32'(bus.mem_req), 1);
    check("rst_ir_write", 32'(bus.ir_write), 1);
    check("rst_src_b", 32'(bus.alu_src_b), 2);
    check("rst_fault", 32'(bus.fault), 0);
    check("rst_reg_write", 32'(bus.reg_write), 0);
    step();
    rst = 1'b0;
    clear_counts();

    // lw with memory always ready
    @(negedge clk); check("lw_c1_ir_write", 32'(bus.ir_write), 1); step();
    @(negedge clk); check("lw_c2_src_a", 32'(bus.alu_src_a), 1); step();
    @(negedge clk); check("lw_c3_src_a", 32'(bus.alu_src_a), 2); step();
    @(negedge clk); check("lw_c4_adr_src", 32'(bus.adr_src), 1); step();
    @(negedge clk);
    check("lw_c5_reg_write", 32'(bus.reg_write), 1);
    check("lw_c5_result_src", 32'(bus.result_src), 1);
    step();
    check("lw_retire_count", 32'(n_retire), 1);

    // sw with 3 stalled cycles in MEMWRITE
    clear_counts();
    bus.op = 7'b0100011;
    step(); step(); step();
    bus.mem_ready = 1'b0;
    @(negedge clk); check("sw_stall_retire", 32'(bus.retire), 0);
    step(); step(); step();
    bus.mem_ready = 1'b1;
    @(negedge clk); check("sw_ready_retire", 32'(bus.retire), 1);
    step();
    check("sw_memwrite_cycles", 32'(n_memwrite), 4);
    check("sw_retire_count", 32'(n_retire), 1);
    check("sw_fault", 32'(bus.fault), 0);

    // back-to-back: long MEMWRITE stall, then FETCH ready exactly at the limit
    step(); step(); step();
    bus.mem_ready = 1'b0;
    repeat (10) step();
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    repeat (15) step();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("limit_ready_fault", 32'(bus.fault), 0);
    check("limit_ready_ir_write", 32'(bus.ir_write), 1);
    step(); step(); step(); step();

    // beq
    clear_counts();
    bus.op = 7'b1100011;
    step(); step();
    @(negedge clk);
    check("beq_branch", 32'(bus.branch), 1);
    check("beq_alu_op", 32'(bus.alu_op), 1);
    step();
    check("beq_branch_cycles", 32'(n_branch), 1);

    // jal
    bus.op = 7'b1101111;
    step(); step();
    @(negedge clk);
    check("jal_pc_update", 32'(bus.pc_update), 1);
    check("jal_imm_src", 32'(bus.imm_src), 3);
    step();
    @(negedge clk); check("jal_wb_reg_write", 32'(bus.reg_write), 1);
    step();

    // R-type and I-type
    bus.op = 7'b0110011; repeat (4) step();
    bus.op = 7'b0010011; repeat (4) step();

    // lui
    clear_counts();
    bus.op = 7'b0110111;
    step(); step();
    @(negedge clk);
    check("lui_imm_src", 32'(bus.imm_src), 4);
`ifdef MAIN_FSM_UTYPE_EN
    check("lui_src_a", 32'(bus.alu_src_a), 3);
    step();
    @(negedge clk); check("lui_wb_reg_write", 32'(bus.reg_write), 1);
    step();
    check("lui_trap_count", 32'(n_trap), 0);
    bus.op = 7'b0010111; repeat (4) step();
`else
    check("lui_trap", 32'(bus.trap), 1);
    step();
    @(negedge clk);
    check("lui_after_trap", 32'(bus.trap), 0);
    check("lui_back_fetch", 32'(bus.ir_write), 1);
    check("lui_trap_count", 32'(n_trap), 1);
    bus.op = 7'b0010111; repeat (3) step();
`endif
    // unknown opcode
    clear_counts();
    bus.op = 7'b1111111; repeat (3) step();
    check("bad_op_trap_count", 32'(n_trap), 1);

    // async reset during a stalled MEMREAD
    clear_counts();
    bus.op = 7'b0000011;
    step(); step(); step();
    bus.mem_ready = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    check("midrst_mem_req", 32'(bus.mem_req), 1);
    check("midrst_adr_src", 32'(bus.adr_src), 0);
    check("midrst_ir_write", 32'(bus.ir_write), 0);
    check("midrst_reg_write", 32'(bus.reg_write), 0);
    step();
    rst = 1'b0;
    repeat (15) step();
    bus.mem_ready = 1'b1;
    @(negedge clk); check("midrst_counter_clear", 32'(bus.fault), 0);
    check("midrst_no_retire", 32'(n_retire), 0);
    repeat (5) step();

    // FETCH timeout: 16 stalled cycles
    bus.mem_ready = 1'b0;
    repeat (15) step();
    @(negedge clk);
    check("to_before_fault", 32'(bus.fault), 0);
    check("to_before_mem_req", 32'(bus.mem_req), 1);
    step();
    @(negedge clk);
    check("to_fault_vector", 32'(outs()), 1);
    bus.mem_ready = 1'b1;
    repeat (3) step();
    @(negedge clk); check("to_fault_sticky", 32'(bus.fault), 1);
    #1 rst = 1'b1;
    #1;
    check("to_rst_fault", 32'(bus.fault), 0);
    check("to_rst_mem_req", 32'(bus.mem_req), 1);
    step();
    rst = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multicycle control unit; successor to the single-cycle main decoder.
- Sequences each RV32I instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives the shared-datapath muxes and enables.
- Adds a memory ready/stall handshake with a bounded-wait timeout, an illegal-opcode trap and a retire pulse.
- Sits between the instruction register and the shared ALU/register file/unified memory port; alu_op feeds the existing ALU decoder.

Parameters:
- MEM_TIMEOUT, 15: max stall cycles per memory state before FAULT; 0 disables the timeout.
- TO_W, $clog2(MEM_TIMEOUT+1) (min 1): stall counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- op  in  7  opcode field of the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  request is a store.
- adr_src  out  1  address select: 0=PC, 1=ALUOut.
- ir_write  out  1  instruction register / OldPC load enable.
- pc_update  out  1  unconditional PC write.
- branch  out  1  conditional PC write (gated by Zero in the datapath).
- reg_write  out  1  register file write.
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero.
- alu_src_b  out  2  00=rs2, 01=imm, 10=const 4.
- alu_op  out  2  00=add, 01=sub/compare, 10=funct-decoded.
- result_src  out  2  00=ALUOut, 01=read data, 10=ALU result.
- imm_src  out  3  000=I, 001=S, 010=B, 011=J, 100=U.
- retire  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  one-cycle pulse on an illegal opcode.
- fault  out  1  sticky memory timeout; cleared only by rst.

Behaviour:
- Moore outputs decoded from the state register. Exceptions:
  - ir_write, pc_update in FETCH are qualified by mem_ready.
  - retire in MEMWRITE is qualified by mem_ready.
  - imm_src is combinational from op in all states: lw/I-ALU 000, sw 001, beq 010, jal 011, lui/auipc 100, else 000.
- Any output not listed for a state is 0.
- Reset (async): state=FETCH, stall counter=0, fault=0. Outputs take FETCH values immediately; ir_write=pc_update=0 until mem_ready.
- A reset mid-access abandons the access; memory must tolerate mem_req remaining high into a fresh fetch.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, ir_write=pc_update=mem_ready. Goes to DECODE on mem_ready.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by op:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - others -> ILLEGAL
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. lw -> MEMREAD, sw -> MEMWRITE. op is held stable by the IR.
- MEMREAD: mem_req=1, adr_src=1. Goes to MEMWB on mem_ready.
- MEMWB: result_src=01, reg_write=1, retire=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, retire=mem_ready. Goes to FETCH on mem_ready.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1 -> FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, retire=1 -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB. rd gets PC+4.
- ILLEGAL: trap=1 for one cycle -> FETCH. No register or memory side effects.
- Stall counter (memory states FETCH/MEMREAD/MEMWRITE):
  - Cleared on entry to any memory state.
  - Increments on each cycle with mem_ready=0, saturating at MEM_TIMEOUT.
  - If count==MEM_TIMEOUT and mem_ready=0 (and MEM_TIMEOUT!=0): go to FAULT.
  - mem_ready in the same cycle wins; no fault.
- FAULT: all outputs 0 except fault=1. Terminal until rst.
- Back-to-back accesses (FETCH directly after MEMWRITE): counter is re-cleared; no bubble required.

Optional Feature:
- Macro MAIN_FSM_UTYPE_EN.
- Defined: lui (0110111) and auipc (0010111) go DECODE -> EXECU -> ALUWB. EXECU: alu_src_b=01, alu_op=00, alu_src_a=11 for lui / 01 for auipc.
- Undefined: both opcodes -> ILLEGAL (trap). The EXECU state and the alu_src_a=11 encoding are never produced; imm_src still reports 100.

Decomposition:
- Package main_fsm_pkg: state enum, opcode constants, alu_src_a/alu_src_b/result_src/imm_src/alu_op encodings. Shared with the datapath and the ALU decoder.
- Sub-module mem_stall_timer (parameter MEM_TIMEOUT): clear, count, and a timeout flag. Instantiated once.

Test Plan:
- Reset with mem_ready=1: lw op=0000011 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 and result_src=01 in cycle 5; retire pulses once.
- sw with mem_ready low 3 cycles in MEMWRITE, MEM_TIMEOUT=15 -> mem_req/mem_write held 4 cycles; retire only on the ready cycle; no fault.
- FETCH with mem_ready=0 for 16 cycles, MEM_TIMEOUT=15 -> fault=1 on the 16th edge; all other outputs 0; rst clears fault and returns to FETCH.
- op=1100011 -> DECODE,BEQ; branch=1, alu_op=01 for exactly 1 cycle. op=1101111 -> JAL then ALUWB; pc_update=1 in JAL.
- op=0110111: without macro -> trap pulse, then FETCH; with MAIN_FSM_UTYPE_EN -> EXECU with alu_src_a=11, then ALUWB with reg_write=1.
- Assert rst mid-MEMREAD -> state FETCH immediately (async), counter 0, no reg_write or retire.
